// File: rtl/aes_collector_pkg.sv
// aes_collector_pkg: shared widths, block type and FSM states for the AES block collector.
package aes_collector_pkg;
  localparam int BLOCK_W = 128;
  localparam int BYTE_W = 8;
  localparam int BYTES_PER_BLOCK = 16;
  localparam int FIFO_DEPTH = 2;
  typedef logic [BLOCK_W-1:0] aes_block_t;
  typedef enum logic {ST_EMPTY, ST_FILL} state_t;
endpackage

// File: rtl/aes_block_fifo.sv
// aes_block_fifo: 2-entry 128-bit FIFO; a push into a full FIFO lands only when a pop frees the head in the same cycle.
module aes_block_fifo
  import aes_collector_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  aes_block_t din,
  output aes_block_t dout,
  output logic       full,
  output logic       empty
);
  aes_block_t mem [FIFO_DEPTH];
  logic wr_q, rd_q, do_push, do_pop;
  logic [1:0] cnt_q;
  assign empty = cnt_q == 2'd0;
  assign full = cnt_q == 2'(FIFO_DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_q];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '{default: '0};
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) mem[wr_q] <= din;
      if (do_push) wr_q <= !wr_q;
      if (do_pop) rd_q <= !rd_q;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/aes_block_collector.sv
// aes_block_collector: packs 16 strobed chip bytes MSB-first into 128-bit blocks behind a 2-deep FIFO.
// Define AES_COLLECTOR_TIMEOUT_EN to discard partial blocks left idle for TIMEOUT_CYCLES.
module aes_block_collector
  import aes_collector_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] chip_data,
  input  logic              sho,
  input  logic              flush,
  input  logic              clear_err,
  output aes_block_t        block_data,
  output logic              block_valid,
  input  logic              block_ready,
  output logic [3:0]        fill_count,
  output logic              overflow,
  output logic              timeout_err
);
  state_t state_q, state_d;
  logic [3:0] fill_q, fill_d;
  logic [BLOCK_W-BYTE_W-1:0] asm_q;
  logic sho_d, accept, take, push_req, pop, full, empty, timeout, ovf_q;
  assign accept = sho && !sho_d;
  assign take = accept && !flush;
  assign pop = block_valid && block_ready;
  assign block_valid = !empty;
  assign fill_count = fill_q;
  assign overflow = ovf_q;
  aes_block_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   ({asm_q, chip_data}),
    .dout  (block_data),
    .full  (full),
    .empty (empty)
  );
  always_comb begin
    state_d = state_q;
    fill_d = fill_q;
    push_req = 1'b0;
    if (flush || timeout) begin
      state_d = ST_EMPTY;
      fill_d = 4'd0;
    end else if (take) begin
      push_req = fill_q == 4'(BYTES_PER_BLOCK - 1);
      fill_d = push_req ? 4'd0 : fill_q + 4'd1;
      state_d = push_req ? ST_EMPTY : ST_FILL;
    end
  end
  // sho_d resets high so a strobe already asserted at reset release is not an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sho_d <= 1'b1;
      state_q <= ST_EMPTY;
      fill_q <= 4'd0;
      asm_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sho_d <= sho;
      state_q <= state_d;
      fill_q <= fill_d;
      if (take) asm_q <= {asm_q[BLOCK_W-2*BYTE_W-1:0], chip_data};
      ovf_q <= (push_req && full && !pop) ? 1'b1 : clear_err ? 1'b0 : ovf_q;
    end
  end
`ifdef AES_COLLECTOR_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q;
  logic terr_q;
  assign timeout = state_q == ST_FILL && !take && idle_q == IDLE_W'(TIMEOUT_CYCLES);
  assign timeout_err = terr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
      terr_q <= 1'b0;
    end else begin
      idle_q <= (state_q != ST_FILL || accept || timeout) ? '0 : idle_q + IDLE_W'(1);
      terr_q <= timeout ? 1'b1 : clear_err ? 1'b0 : terr_q;
    end
  end
`else
  assign timeout = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule
